apb_arbiter: RTL and testbench

Two-requester round-robin arbiter in front of the MCU's single APB master request port (transfer/ready/addr/wdata/rdata/write). Requester 0 is the RV32I core data port; requester 1 is a second bus master (DMA/debug loader). The block serialises their requests, holds the granted request stable until the downstream `ready`, returns read data to the winner, and enforces a per-transfer timeout so a hung peripheral cannot stall the core forever.

---
 rtl/apb_arb_pkg.sv | 21 ++
 rtl/apb_arb_timeout.sv | 29 ++
 rtl/apb_arbiter.sv | 117 +++++++++++
 tb/tb_apb_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB arbiter: FSM states, requester ids.
// Requester 0 is the core data port, requester 1 the auxiliary bus master.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } arb_state_e;

   typedef logic req_id_t;

   localparam req_id_t REQ_CPU = 1'b0;
   localparam req_id_t REQ_AUX = 1'b1;

   function automatic logic [1:0] req_onehot(input req_id_t id);
      return (id == REQ_AUX) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/apb_arb_timeout.sv
// Saturating WAIT-cycle counter; expired is high once TIMEOUT_CYCLES stall cycles have elapsed.
// No latency of its own; TIMEOUT_CYCLES=0 keeps expired permanently low.
module apb_arb_timeout #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (TIMEOUT_CYCLES != 0) && (count >= CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/apb_arbiter.sv
// Round-robin arbiter serialising two requesters onto one APB master port with a WAIT timeout.
// Request-to-ready latency >= 2 cycles; requests are held by the requester until its ready pulse.
module apb_arbiter
   import apb_arb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              transfer0,
   input  logic              transfer1,
   input  logic              write0,
   input  logic              write1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              ready0,
   output logic              ready1,
   output logic              err0,
   output logic              err1,
   output logic              transfer,
   output logic              write,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   input  logic              ready,
   output logic [1:0]        grant,
   output logic              busy
);

   arb_state_e state;
   req_id_t    owner;
   req_id_t    last_grant;
   req_id_t    pick;
   logic       expired;
   logic       done_ok;
   logic       done_err;

   // On a tie the requester that did not win last time goes first.
   always_comb begin
      pick = REQ_CPU;
      if (transfer0 && transfer1) begin
         pick = ~last_grant;
      end else if (transfer1) begin
         pick = REQ_AUX;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= REQ_CPU;
         last_grant <= REQ_AUX;
         write      <= 1'b0;
         addr       <= '0;
         wdata      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (transfer0 || transfer1) begin
                  owner      <= pick;
                  last_grant <= pick;
                  write      <= (pick == REQ_AUX) ? write1 : write0;
                  addr       <= (pick == REQ_AUX) ? addr1  : addr0;
                  wdata      <= (pick == REQ_AUX) ? wdata1 : wdata0;
                  state      <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (ready) begin
                  state <= IDLE;
               end else if (expired) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   apb_arb_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (state == ISSUE),
      .enable  ((state == WAIT) && !ready),
      .expired (expired)
   );

   // A real completion beats a timeout landing in the same cycle.
   assign done_ok  = (state == WAIT) && ready;
   assign done_err = (state == WAIT) && !ready && expired;

   assign transfer = (state == ISSUE);
   assign busy     = (state != IDLE);
   assign grant    = busy ? req_onehot(owner) : 2'b00;

   assign ready0 = (done_ok || done_err) && (owner == REQ_CPU);
   assign ready1 = (done_ok || done_err) && (owner == REQ_AUX);
   assign err0   = done_err && (owner == REQ_CPU);
   assign err1   = done_err && (owner == REQ_AUX);
   assign rdata0 = (done_ok && (owner == REQ_CPU)) ? rdata : '0;
   assign rdata1 = (done_ok && (owner == REQ_AUX)) ? rdata : '0;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed scenarios plus randomized traffic against a cycle-timeline model.
module tb_apb_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // main instance, TIMEOUT_CYCLES = 4
   logic        t0, t1, w0, w1, r0, r1, e0, e1, xfer, wr, ready, busy;
   logic [31:0] a0, a1, wd0, wd1, rd0, rd1, addr, wdata, rdata;
   logic [1:0]  grant;

   // second instance with the timeout disabled
   logic        z_t0, z_t1, z_w0, z_w1, z_r0, z_r1, z_e0, z_e1, z_xfer, z_wr, z_ready, z_busy;
   logic [31:0] z_a0, z_a1, z_wd0, z_wd1, z_rd0, z_rd1, z_addr, z_wdata, z_rdata;
   logic [1:0]  z_grant;

   apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset),
      .transfer0(t0), .transfer1(t1), .write0(w0), .write1(w1),
      .addr0(a0), .addr1(a1), .wdata0(wd0), .wdata1(wd1),
      .rdata0(rd0), .rdata1(rd1), .ready0(r0), .ready1(r1), .err0(e0), .err1(e1),
      .transfer(xfer), .write(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .grant(grant), .busy(busy)
   );

   apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(0)) dut_nt (
      .clk(clk), .reset(reset),
      .transfer0(z_t0), .transfer1(z_t1), .write0(z_w0), .write1(z_w1),
      .addr0(z_a0), .addr1(z_a1), .wdata0(z_wd0), .wdata1(z_wd1),
      .rdata0(z_rd0), .rdata1(z_rd1), .ready0(z_r0), .ready1(z_r1), .err0(z_e0), .err1(z_e1),
      .transfer(z_xfer), .write(z_wr), .addr(z_addr), .wdata(z_wdata),
      .rdata(z_rdata), .ready(z_ready), .grant(z_grant), .busy(z_busy)
   );

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      t0 = 0; t1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; wd0 = '0; wd1 = '0;
      ready = 0; rdata = '0;
      z_t0 = 0; z_t1 = 0; z_w0 = 0; z_w1 = 0; z_a0 = '0; z_a1 = '0; z_wd0 = '0; z_wd1 = '0;
      z_ready = 0; z_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 0;
      adv();
      adv();
      reset = 1;
   endtask

   task automatic test_reset();
      logic [136:0] obs;
      idle_inputs();
      reset = 0;
      t0 = 1; t1 = 1; ready = 1; rdata = 32'hA5A5_A5A5;
      adv();
      @(negedge clk);
      obs = {xfer, r0, r1, e0, e1, busy, grant, wr, addr, wdata, rd0, rd1};
      n_chk++;
      if (obs !== '0) $display("FAIL reset_outputs got=%h want=0", obs);
      else n_pass++;
      n_chk++;
      if (z_busy !== 1'b0) $display("FAIL reset_busy_nt got=%b want=0", z_busy);
      else n_pass++;
   endtask

   task automatic test_single_read();
      int n_x;
      int n_r1;
      do_reset();
      t0 = 1; w0 = 0; a0 = 32'h1000_0004; wd0 = $urandom;
      n_x = 0; n_r1 = 0;
      @(negedge clk);
      n_chk++;
      if ({xfer, busy} !== 2'b00) $display("FAIL sr_idle got=%b want=00", {xfer, busy});
      else n_pass++;
      adv();
      @(negedge clk);
      n_x += int'(xfer);
      n_chk++;
      if ({xfer, busy, grant, wr, addr} !== {1'b1, 1'b1, 2'b01, 1'b0, 32'h1000_0004})
         $display("FAIL sr_issue got=%b%b%b%b %h want=1 1 01 0 10000004", xfer, busy, grant, wr, addr);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
         adv();
         if (k == 2) begin ready = 1; rdata = 32'hDEAD_BEEF; end
         @(negedge clk);
         n_x += int'(xfer);
         n_r1 += int'(r1);
         if (k < 2) begin
            n_chk++;
            if ({r0, e0} !== 2'b00) $display("FAIL sr_wait%0d got=%b want=00", k, {r0, e0});
            else n_pass++;
         end else begin
            n_chk++;
            if ({r0, e0, rd0} !== {1'b1, 1'b0, 32'hDEAD_BEEF})
               $display("FAIL sr_resp got=%b%b %h want=1 0 deadbeef", r0, e0, rd0);
            else n_pass++;
         end
      end
      adv();
      ready = 0; t0 = 0;
      @(negedge clk);
      n_chk++;
      if ({busy, grant} !== 3'b000) $display("FAIL sr_back_idle got=%b want=000", {busy, grant});
      else n_pass++;
      n_chk++;
      if ({n_x, n_r1} !== {32'd1, 32'd0}) $display("FAIL sr_pulses got xfer=%0d r1=%0d want 1 0", n_x, n_r1);
      else n_pass++;
   endtask

   // Both requesters held continuously: grants alternate, 3 cycles apart.
   task automatic test_tie();
      logic last;
      int   win;
      logic [31:0] v;
      do_reset();
      t0 = 1; w0 = 1; a0 = 32'h1000_1000; wd0 = 32'h55;
      t1 = 1; w1 = 0; a1 = 32'h1000_2000; wd1 = $urandom;
      last = 1'b1;
      for (int g = 0; g < 4; g++) begin
         win = last ? 0 : 1;
         @(negedge clk);
         n_chk++;
         if ({xfer, busy} !== 2'b00) $display("FAIL tie_idle%0d got=%b want=00", g, {xfer, busy});
         else n_pass++;
         adv();
         @(negedge clk);
         n_chk++;
         if ({xfer, grant, wr, addr, wdata} !== {1'b1, (win == 1) ? 2'b10 : 2'b01,
                                                 (win == 1) ? {w1, a1, wd1} : {w0, a0, wd0}})
            $display("FAIL tie_grant%0d got=%b %b %b %h %h want winner %0d", g, xfer, grant, wr, addr, wdata, win);
         else n_pass++;
         adv();
         v = $urandom;
         ready = 1; rdata = v;
         @(negedge clk);
         n_chk++;
         if ({r0, r1, e0, e1, rd0, rd1} !== {win == 0, win == 1, 2'b00,
                                             (win == 0) ? v : 32'h0, (win == 1) ? v : 32'h0})
            $display("FAIL tie_resp%0d got=%b%b%b%b %h %h want winner %0d data %h", g, r0, r1, e0, e1, rd0, rd1, win, v);
         else n_pass++;
         adv();
         ready = 0;
         last = (win == 1);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] want;
      do_reset();
      t1 = 1; w1 = 0; a1 = $urandom; wd1 = $urandom;
      adv();
      @(negedge clk);
      n_chk++;
      if ({xfer, grant} !== 3'b110) $display("FAIL to_issue got=%b want=110", {xfer, grant});
      else n_pass++;
      rdata = 32'hFFFF_FFFF;
      for (int k = 0; k <= 10; k++) begin
         adv();
         if (k == 5) begin t1 = 0; t0 = 1; end
         ready = (k == 10);
         @(negedge clk);
         want = {1'b0, k == 4, 1'b0, k == 4, 1'b1, 1'b0, 2'b10};
         n_chk++;
         if ({r0, r1, e0, e1, busy, xfer, grant} !== want || rd1 !== 32'h0)
            $display("FAIL to_k%0d got=%b rd1=%h want=%b rd1=0", k, {r0, r1, e0, e1, busy, xfer, grant}, rd1, want);
         else n_pass++;
      end
      adv();
      ready = 0;
      @(negedge clk);
      n_chk++;
      if ({busy, xfer} !== 2'b00) $display("FAIL to_idle got=%b want=00", {busy, xfer});
      else n_pass++;
      adv();
      @(negedge clk);
      n_chk++;
      if ({xfer, grant} !== 3'b101) $display("FAIL to_next_grant got=%b want=101", {xfer, grant});
      else n_pass++;
   endtask

   task automatic test_same_cycle();
      logic [31:0] v;
      do_reset();
      t0 = 1; w0 = 0; a0 = $urandom;
      adv();
      adv();
      for (int k = 0; k <= 4; k++) begin
         v = $urandom;
         ready = (k == 4); rdata = v;
         @(negedge clk);
         if (k < 4) begin
            n_chk++;
            if ({r0, e0} !== 2'b00) $display("FAIL sc_k%0d got=%b want=00", k, {r0, e0});
            else n_pass++;
         end else begin
            n_chk++;
            if ({r0, e0, rd0} !== {1'b1, 1'b0, v}) $display("FAIL sc_resp got=%b%b %h want=1 0 %h", r0, e0, rd0, v);
            else n_pass++;
         end
         adv();
      end
      ready = 0; t0 = 0;
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0) $display("FAIL sc_idle got=%b want=0", busy);
      else n_pass++;
   endtask

   task automatic test_reset_wait();
      logic [136:0] obs;
      do_reset();
      t0 = 1; w0 = 1; a0 = $urandom | 32'h1; wd0 = $urandom | 32'h1;
      adv();
      adv();
      adv();
      reset = 0; t1 = 1; w1 = 0; a1 = $urandom;
      adv();
      reset = 1;
      @(negedge clk);
      obs = {xfer, r0, r1, e0, e1, busy, grant, wr, addr, wdata, rd0, rd1};
      n_chk++;
      if (obs !== '0) $display("FAIL rw_reset got=%h want=0", obs);
      else n_pass++;
      adv();
      @(negedge clk);
      n_chk++;
      if ({xfer, grant, addr} !== {1'b1, 2'b01, a0}) $display("FAIL rw_first got=%b %b %h want=1 01 %h", xfer, grant, addr, a0);
      else n_pass++;
   endtask

   task automatic test_no_timeout();
      int bad;
      logic [31:0] v;
      do_reset();
      z_t0 = 1; z_w0 = 0; z_a0 = $urandom;
      adv();
      @(negedge clk);
      n_chk++;
      if ({z_xfer, z_addr} !== {1'b1, z_a0}) $display("FAIL nt_issue got=%b %h want=1 %h", z_xfer, z_addr, z_a0);
      else n_pass++;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         adv();
         z_rdata = $urandom;
         @(negedge clk);
         if (z_r0 || z_e0 || !z_busy) bad++;
      end
      n_chk++;
      if (bad !== 0) $display("FAIL nt_stall got=%0d bad cycles want=0", bad);
      else n_pass++;
      adv();
      v = $urandom;
      z_ready = 1; z_rdata = v;
      @(negedge clk);
      n_chk++;
      if ({z_r0, z_e0, z_rd0} !== {1'b1, 1'b0, v}) $display("FAIL nt_resp got=%b%b %h want=1 0 %h", z_r0, z_e0, z_rd0, v);
      else n_pass++;
      adv();
      idle_inputs();
   endtask

   // Transaction timeline: grant in idle cycle g -> transfer at g+1, response at g+2+min(lat,4), idle after g+2+lat.
   task automatic test_random();
      logic [1:0]  pend;
      logic [31:0] ra [2];
      logic [31:0] rwd [2];
      logic        rw [2];
      int          t_grant, t_resp, t_end, lat, win;
      logic        last, exp_busy, exp_xfer, exp_pulse, exp_err;
      logic [31:0] v;
      logic [7:0]  want;
      do_reset();
      pend = 2'b00; last = 1'b1;
      t_grant = -10; t_resp = -10; t_end = -1; lat = 0; win = 0;
      for (int i = 0; i < 2; i++) begin ra[i] = '0; rwd[i] = '0; rw[i] = 1'b0; end
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1; ra[i] = $urandom; rwd[i] = $urandom; rw[i] = 1'($urandom_range(0, 1));
            end
         end
         t0 = pend[0]; w0 = rw[0]; a0 = ra[0]; wd0 = rwd[0];
         t1 = pend[1]; w1 = rw[1]; a1 = ra[1]; wd1 = rwd[1];
         v = $urandom;
         ready = (c == t_grant + 2 + lat); rdata = v;
         @(negedge clk);
         exp_busy  = (c <= t_end);
         exp_xfer  = (c == t_grant + 1);
         exp_pulse = (c == t_resp);
         exp_err   = exp_pulse && (lat > 4);
         want = {exp_pulse && win == 0, exp_pulse && win == 1, exp_err && win == 0, exp_err && win == 1,
                 exp_busy, exp_xfer, exp_busy ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00};
         n_chk++;
         if ({r0, r1, e0, e1, busy, xfer, grant} !== want)
            $display("FAIL rnd_ctl c=%0d got=%b want=%b", c, {r0, r1, e0, e1, busy, xfer, grant}, want);
         else n_pass++;
         n_chk++;
         if ({rd0, rd1} !== {(exp_pulse && !exp_err && win == 0) ? v : 32'h0,
                             (exp_pulse && !exp_err && win == 1) ? v : 32'h0})
            $display("FAIL rnd_rdata c=%0d got=%h %h want data %h to %0d", c, rd0, rd1, v, win);
         else n_pass++;
         if (exp_xfer) begin
            n_chk++;
            if ({wr, addr, wdata} !== {rw[win], ra[win], rwd[win]})
               $display("FAIL rnd_fields c=%0d got=%b %h %h want=%b %h %h", c, wr, addr, wdata, rw[win], ra[win], rwd[win]);
            else n_pass++;
         end
         if (exp_pulse) pend[win] = 1'b0;
         if (!exp_busy && pend != 2'b00) begin
            win = (pend == 2'b11) ? (last ? 0 : 1) : (pend[1] ? 1 : 0);
            last = (win == 1);
            lat = $urandom_range(0, 7);
            t_grant = c;
            t_end = c + 2 + lat;
            t_resp = c + 2 + ((lat > 4) ? 4 : lat);
         end
         adv();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_read();
      test_tie();
      test_timeout();
      test_same_cycle();
      test_reset_wait();
      test_no_timeout();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
